// File: rtl/vertexinput_axil_frontend.sv
// AXI4-Lite slave front-end for the vertexinput register slices: buffers AW/W/AR,
// decodes the word index, strobes one slice per transaction and returns B/R responses.
module vertexinput_axil_frontend #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS-1:0]            mem_w_req,
  output logic [DATA_WIDTH-1:0]          mem_w_data,
  output logic [NUM_REGS-1:0]            mem_r_req,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] mem_r_data_local
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_t;

  state_t                state_q, state_d;
  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  ar_full_q, ar_full_d;
  logic [IDX_W-1:0]      ar_idx_q, ar_idx_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            resp_q, resp_d;
  logic                  last_wr_q, last_wr_d;
  logic [DATA_WIDTH-1:0] mem_w_data_q, mem_w_data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] slice_data;
  logic                  grant_wr, grant_rd;
  logic                  unused_addr_bits;

  // Byte-lane bits never take part in decode.
  assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  function automatic logic out_of_range(input logic [IDX_W-1:0] idx);
    return int'(idx) >= NUM_REGS;
  endfunction

  always_comb begin
    slice_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == IDX_W'(i)) slice_data = mem_r_data_local[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    aw_full_d    = aw_full_q;
    aw_idx_d     = aw_idx_q;
    w_full_d     = w_full_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    ar_full_d    = ar_full_q;
    ar_idx_d     = ar_idx_q;
    idx_d        = idx_q;
    resp_d       = resp_q;
    last_wr_d    = last_wr_q;
    mem_w_data_d = mem_w_data_q;
    rdata_d      = rdata_q;
    bresp_d      = bresp_q;
    rresp_d      = rresp_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;

    if (s_axil_awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:2];
    end
    if (s_axil_wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end
    if (s_axil_arvalid && !ar_full_q) begin
      ar_full_d = 1'b1;
      ar_idx_d  = s_axil_araddr[ADDR_WIDTH-1:2];
    end

    case (state_q)
      IDLE: begin
        // On a write/read conflict, grant the type that did not win last time.
        if (aw_full_q && w_full_q && (!ar_full_q || !last_wr_q)) grant_wr = 1'b1;
        else if (ar_full_q) grant_rd = 1'b1;
        if (grant_wr) begin
          mem_w_data_d = w_data_q;
          idx_d        = aw_idx_q;
          last_wr_d    = 1'b1;
          if (out_of_range(aw_idx_q)) resp_d = RESP_DECERR;
          else if (w_strb_q != '1)    resp_d = RESP_SLVERR;
          else                        resp_d = RESP_OKAY;
          state_d = WR_REQ;
        end else if (grant_rd) begin
          idx_d     = ar_idx_q;
          last_wr_d = 1'b0;
          resp_d    = out_of_range(ar_idx_q) ? RESP_DECERR : RESP_OKAY;
          state_d   = RD_REQ;
        end
      end
      WR_REQ: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        bresp_d   = resp_q;
        state_d   = WR_RESP;
      end
      WR_RESP: if (s_axil_bready) state_d = IDLE;
      RD_REQ: begin
        ar_full_d = 1'b0;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = slice_data;
        rresp_d = resp_q;
        state_d = RD_RESP;
      end
      RD_RESP: if (s_axil_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      aw_full_q    <= 1'b0;
      aw_idx_q     <= '0;
      w_full_q     <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      ar_full_q    <= 1'b0;
      ar_idx_q     <= '0;
      idx_q        <= '0;
      resp_q       <= RESP_OKAY;
      last_wr_q    <= 1'b0;
      mem_w_data_q <= '0;
      rdata_q      <= '0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      aw_full_q    <= aw_full_d;
      aw_idx_q     <= aw_idx_d;
      w_full_q     <= w_full_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      ar_full_q    <= ar_full_d;
      ar_idx_q     <= ar_idx_d;
      idx_q        <= idx_d;
      resp_q       <= resp_d;
      last_wr_q    <= last_wr_d;
      mem_w_data_q <= mem_w_data_d;
      rdata_q      <= rdata_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
    end
  end

  // Strobes decode straight from state so a reset removes them immediately.
  always_comb begin
    mem_w_req = '0;
    mem_r_req = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_w_req[i] = (state_q == WR_REQ) && (resp_q == RESP_OKAY) && (idx_q == IDX_W'(i));
      mem_r_req[i] = (state_q == RD_REQ) && (idx_q == IDX_W'(i));
    end
  end

  assign s_axil_awready = !aw_full_q;
  assign s_axil_wready  = !w_full_q;
  assign s_axil_arready = !ar_full_q;
  assign s_axil_bvalid  = (state_q == WR_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = (state_q == RD_RESP);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign mem_w_data     = mem_w_data_q;

endmodule

// File: tb/tb_vertexinput_axil_frontend.sv
// Randomised self-checking bench for vertexinput_axil_frontend; expected responses,
// latencies, strobes and grant order come from a transaction-level model.
module tb_vertexinput_axil_frontend;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int NR = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [AW-1:0]       s_axil_awaddr;
   logic                s_axil_awvalid;
   logic                s_axil_awready;
   logic [DW-1:0]       s_axil_wdata;
   logic [DW/8-1:0]     s_axil_wstrb;
   logic                s_axil_wvalid;
   logic                s_axil_wready;
   logic [1:0]          s_axil_bresp;
   logic                s_axil_bvalid;
   logic                s_axil_bready;
   logic [AW-1:0]       s_axil_araddr;
   logic                s_axil_arvalid;
   logic                s_axil_arready;
   logic [DW-1:0]       s_axil_rdata;
   logic [1:0]          s_axil_rresp;
   logic                s_axil_rvalid;
   logic                s_axil_rready;
   logic [NR-1:0]       mem_w_req;
   logic [DW-1:0]       mem_w_data;
   logic [NR-1:0]       mem_r_req;
   logic [NR*DW-1:0]    mem_r_data_local;

   logic [DW-1:0]       sliceData [NR];

   int checkCount = 0;
   int errorCount = 0;

   vertexinput_axil_frontend #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
      .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
      .s_axil_rready(s_axil_rready),
      .mem_w_req(mem_w_req), .mem_w_data(mem_w_data), .mem_r_req(mem_r_req),
      .mem_r_data_local(mem_r_data_local)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   // The slice array is modelled as a bank of words the bench owns.
   for (genvar g = 0; g < NR; g++) begin : g_slice
      assign mem_r_data_local[g*DW +: DW] = sliceData[g];
   end

   // Strobe monitor: logs every slice access and counts protocol violations.
   int            wStrobeCount = 0;
   int            rStrobeCount = 0;
   int            violationCount = 0;
   int            consecCount = 0;
   logic          prevR = 1'b0;
   logic [NR-1:0] lastWReq = '0;
   logic [NR-1:0] lastRReq = '0;
   logic [DW-1:0] lastWData = '0;
   int            grantLog[$];

   always @(negedge clk) begin
      if (mem_w_req != '0) begin
         wStrobeCount++;
         lastWReq = mem_w_req;
         lastWData = mem_w_data;
         grantLog.push_back(1);
      end
      if (mem_r_req != '0) begin
         rStrobeCount++;
         lastRReq = mem_r_req;
         grantLog.push_back(2);
      end
      if ((mem_w_req != '0) && (mem_r_req != '0)) violationCount++;
      if ($countones(mem_w_req) > 1 || $countones(mem_r_req) > 1) violationCount++;
      if ((mem_r_req != '0) && prevR) consecCount++;
      prevR = (mem_r_req != '0);
   end

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference decode: word index, response code and one-hot strobe from plain arithmetic.
   function automatic logic [1:0] modelResp(input logic [AW-1:0] addr, input logic [3:0] strb, input bit isWrite);
      int idx;
      idx = int'(addr) / 4;
      if (idx >= NR) return 2'b11;
      if (isWrite && strb != 4'hF) return 2'b10;
      return 2'b00;
   endfunction

   // One complete AXI write with independently delayed AW and W, then a B stall.
   task automatic applyWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                             input int awDelay, input int wDelay, input int bDelay);
      int cyc = 0;
      int hsCyc = -100;
      int bvCyc = -100;
      int w0, r0, idx, stallBad;
      bit awDone = 0;
      bit wDone = 0;
      logic [1:0] expResp;
      idx = int'(addr) / 4;
      expResp = modelResp(addr, strb, 1'b1);
      w0 = wStrobeCount;
      r0 = rStrobeCount;
      s_axil_awaddr = addr;
      s_axil_wdata = data;
      s_axil_wstrb = strb;
      while (!(awDone && wDone) && cyc < 40) begin
         s_axil_awvalid = !awDone && (cyc >= awDelay);
         s_axil_wvalid = !wDone && (cyc >= wDelay);
         if (s_axil_awvalid && s_axil_awready) awDone = 1;
         if (s_axil_wvalid && s_axil_wready) wDone = 1;
         if (awDone && wDone) hsCyc = cyc;
         @(negedge clk);
         cyc++;
         s_axil_awvalid = 1'b0;
         s_axil_wvalid = 1'b0;
      end
      checkOutput("wr_accept", 32'(awDone && wDone), 32'd1);
      for (int k = 0; k < 20 && bvCyc < 0; k++) begin
         if (s_axil_bvalid) bvCyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      checkOutput("wr_latency", 32'(bvCyc - hsCyc), 32'd3);
      checkOutput("bresp", 32'(s_axil_bresp), 32'(expResp));
      stallBad = 0;
      for (int k = 0; k < bDelay; k++) begin
         @(negedge clk);
         if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== expResp) stallBad++;
      end
      checkOutput("b_stall_hold", 32'(stallBad), 32'd0);
      s_axil_bready = 1'b1;
      @(negedge clk);
      s_axil_bready = 1'b0;
      checkOutput("bvalid_clear", 32'(s_axil_bvalid), 32'd0);
      checkOutput("wreq_count", 32'(wStrobeCount - w0), (expResp == 2'b00) ? 32'd1 : 32'd0);
      if (expResp == 2'b00) begin
         checkOutput("wreq_vec", 32'(lastWReq), 32'd1 << idx);
         checkOutput("wreq_data", lastWData, data);
      end
      checkOutput("mem_w_data", mem_w_data, data);
      checkOutput("rreq_in_write", 32'(rStrobeCount - r0), 32'd0);
   endtask

   // One complete AXI read with a delayed AR, then an R stall.
   task automatic applyRead(input logic [AW-1:0] addr, input int arDelay, input int rDelay);
      int cyc = 0;
      int hsCyc = -100;
      int rvCyc = -100;
      int w0, r0, idx, stallBad;
      bit arDone = 0;
      logic [DW-1:0] expData;
      logic [1:0] expResp;
      idx = int'(addr) / 4;
      expResp = modelResp(addr, 4'hF, 1'b0);
      expData = '0;
      if (idx < NR) expData = sliceData[idx];
      w0 = wStrobeCount;
      r0 = rStrobeCount;
      s_axil_araddr = addr;
      while (!arDone && cyc < 40) begin
         s_axil_arvalid = (cyc >= arDelay);
         if (s_axil_arvalid && s_axil_arready) begin
            arDone = 1;
            hsCyc = cyc;
         end
         @(negedge clk);
         cyc++;
         s_axil_arvalid = 1'b0;
      end
      checkOutput("rd_accept", 32'(arDone), 32'd1);
      for (int k = 0; k < 20 && rvCyc < 0; k++) begin
         if (s_axil_rvalid) rvCyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      checkOutput("rd_latency", 32'(rvCyc - hsCyc), 32'd4);
      checkOutput("rresp", 32'(s_axil_rresp), 32'(expResp));
      checkOutput("rdata", s_axil_rdata, expData);
      stallBad = 0;
      for (int k = 0; k < rDelay; k++) begin
         @(negedge clk);
         if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== expData) stallBad++;
      end
      checkOutput("r_stall_hold", 32'(stallBad), 32'd0);
      s_axil_rready = 1'b1;
      @(negedge clk);
      s_axil_rready = 1'b0;
      checkOutput("rvalid_clear", 32'(s_axil_rvalid), 32'd0);
      checkOutput("rreq_count", 32'(rStrobeCount - r0), (idx < NR) ? 32'd1 : 32'd0);
      if (idx < NR) checkOutput("rreq_vec", 32'(lastRReq), 32'd1 << idx);
      checkOutput("wreq_in_read", 32'(wStrobeCount - w0), 32'd0);
   endtask

   // Write and read presented together each round; the model predicts the grant order.
   task automatic applyConflictRounds(input int rounds);
      int expLog[$];
      bit lastWasWrite = 0;
      bit firstW;
      grantLog.delete();
      s_axil_bready = 1'b1;
      s_axil_rready = 1'b1;
      for (int r = 0; r < rounds; r++) begin
         bit awDone = 0;
         bit wDone = 0;
         bit arDone = 0;
         bit bSeen = 0;
         bit rSeen = 0;
         firstW = !lastWasWrite;
         expLog.push_back(firstW ? 1 : 2);
         expLog.push_back(firstW ? 2 : 1);
         lastWasWrite = !firstW;
         s_axil_awaddr = AW'(4 * $urandom_range(0, NR - 1));
         s_axil_wdata = $urandom();
         s_axil_wstrb = 4'hF;
         s_axil_araddr = AW'(4 * $urandom_range(0, NR - 1));
         for (int c = 0; c < 40 && !(bSeen && rSeen); c++) begin
            s_axil_awvalid = !awDone;
            s_axil_wvalid = !wDone;
            s_axil_arvalid = !arDone;
            if (s_axil_awready) awDone = 1;
            if (s_axil_wready) wDone = 1;
            if (s_axil_arready) arDone = 1;
            @(negedge clk);
            s_axil_awvalid = 1'b0;
            s_axil_wvalid = 1'b0;
            s_axil_arvalid = 1'b0;
            if (s_axil_bvalid) bSeen = 1;
            if (s_axil_rvalid) rSeen = 1;
         end
         checkOutput($sformatf("conflict%0d_done", r), 32'(bSeen && rSeen), 32'd1);
         @(negedge clk);
      end
      s_axil_bready = 1'b0;
      s_axil_rready = 1'b0;
      checkOutput("grant_count", 32'(grantLog.size()), 32'(expLog.size()));
      for (int k = 0; k < expLog.size(); k++) begin
         checkOutput($sformatf("grant%0d", k), 32'(grantLog[k]), 32'(expLog[k]));
      end
   endtask

   // Random mix of reads and writes over in-range, out-of-range and partial-strobe cases.
   task automatic applyStimulus(input int count);
      logic [AW-1:0] addr;
      logic [3:0] strb;
      for (int n = 0; n < count; n++) begin
         for (int s = 0; s < NR; s++) sliceData[s] = $urandom();
         if ($urandom_range(0, 4) == 0) addr = AW'($urandom_range(0, 4095));
         else addr = AW'(4 * $urandom_range(0, NR + 1) + $urandom_range(0, 3));
         strb = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
         if ($urandom_range(0, 1) == 1)
            applyWrite(addr, $urandom(), strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            applyRead(addr, $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   // Long R stall followed by a reset landing in the middle of the response.
   task automatic applyResetMidRead();
      int stallBad = 0;
      int r0;
      bit rSeen = 0;
      logic [DW-1:0] expData;
      sliceData[5] = $urandom();
      expData = sliceData[5];
      s_axil_araddr = 12'h014;
      s_axil_arvalid = 1'b1;
      @(negedge clk);
      s_axil_arvalid = 1'b0;
      for (int c = 0; c < 20 && !rSeen; c++) begin
         if (s_axil_rvalid) rSeen = 1;
         else @(negedge clk);
      end
      checkOutput("rst_rd_rvalid", 32'(rSeen), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== expData) stallBad++;
      end
      checkOutput("rst_rd_stall", 32'(stallBad), 32'd0);
      r0 = rStrobeCount;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
      checkOutput("rst_readies", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd7);
      checkOutput("rst_rdata", s_axil_rdata, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("rst_no_replay", 32'(rStrobeCount - r0), 32'd0);
   endtask

   // Main sequence: reset values, conflict ordering, directed cases, random mix, reset recovery.
   initial begin
      rst = 1'b1;
      s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
      s_axil_bready = 1'b0;
      s_axil_araddr = '0; s_axil_arvalid = 1'b0;
      s_axil_rready = 1'b0;
      for (int s = 0; s < NR; s++) sliceData[s] = $urandom();
      repeat (3) @(negedge clk);
      checkOutput("reset_valids", 32'({s_axil_bvalid, s_axil_rvalid}), 32'd0);
      checkOutput("reset_strobes", 32'({mem_w_req, mem_r_req}), 32'd0);
      checkOutput("reset_mem_w_data", mem_w_data, 32'd0);
      checkOutput("reset_rdata", s_axil_rdata, 32'd0);
      checkOutput("reset_resps", 32'({s_axil_bresp, s_axil_rresp}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_readies", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd7);

      applyConflictRounds(4);

      applyWrite(12'h008, 32'hDEADBEEF, 4'hF, 0, 2, 0);
      applyRead(12'h008, 0, 0);
      applyWrite(12'h00C, 32'h12345678, 4'hF, 0, 0, 1);
      applyWrite(12'h01C, 32'hCAFEF00D, 4'hF, 2, 0, 0);
      applyRead(12'h020, 0, 0);
      applyWrite(12'h020, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
      applyWrite(12'h004, 32'h0BADF00D, 4'b0011, 0, 0, 0);

      applyStimulus(40);
      applyResetMidRead();

      checkOutput("strobe_overlap", 32'(violationCount), 32'd0);
      checkOutput("rreq_consecutive", 32'(consecCount), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Watchdog against a hung handshake anywhere in the sequence.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
